// File: rtl/divu_param.sv
`default_nettype none
// ============================================================================
// Module      : divu_param
// Description : Bus-mapped divide unit. Performs 2W/W or W/W division, signed
//               or unsigned, one quotient bit per CE_R step (non-restoring).
//               Detects quotient-range overflow and saturates, raises overflow
//               and completion interrupts, and stalls bus accesses while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module divu_param #(
    parameter int          W    = 32,
    parameter logic [31:0] BASE = 32'hFFFFFF00
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        CE_R,
    input  logic        CE_F,
    input  logic        RES_N,
    input  logic [31:0] IBUS_A,
    input  logic [31:0] IBUS_DI,
    input  logic [3:0]  IBUS_BA,
    input  logic        IBUS_WE,
    input  logic        IBUS_REQ,
    output logic [31:0] IBUS_DO,
    output logic        IBUS_BUSY,
    output logic        IBUS_ACT,
    output logic        IRQ,
    output logic [7:0]  VEC
);

    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_load = 3'd1;
    localparam logic [2:0] c_st_iter = 3'd2;
    localparam logic [2:0] c_st_fix  = 3'd3;
    localparam logic [2:0] c_st_wb   = 3'd4;

    localparam int              c_cw   = $clog2(W + 1);
    localparam logic [c_cw-1:0] c_last = c_cw'(W - 1);
    localparam logic [W-1:0]    c_smax = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]    c_smin = {1'b1, {(W-1){1'b0}}};

    // Architectural registers
    logic [W-1:0]    r_dvsr, r_dvdnth, r_dvdntl;
    logic [15:0]     r_vcrdiv;
    logic            r_ovf, r_ovfie, r_uns, r_done, r_doneie, r_bsy;
    // Divider datapath state
    logic [2:0]      r_state;
    logic [c_cw-1:0] r_cnt;
    logic [W+1:0]    r_rem;          // signed partial remainder with carry bits
    logic [W-1:0]    r_quo;          // dividend low half shifting into quotient
    logic [W-1:0]    r_dsr;          // divisor magnitude
    logic            r_qneg, r_rneg, r_xovf;
    logic [31:0]     r_do;

    // Narrow registers read back widened according to the current mode
    function automatic logic [31:0] f_ext(input logic [W-1:0] v, input logic uns);
        logic [31:0] r;
        r        = {32{~uns & v[W-1]}};
        r[W-1:0] = v;
        return r;
    endfunction

    logic [31:0]  w_off, w_rdata, w_wdata;
    logic [W-1:0] w_wdw;
    logic [2:0]   w_idx;
    logic         w_act, w_sel, w_acc, w_wr, w_start, w_reset;

    assign w_off   = IBUS_A - BASE;
    assign w_act   = (w_off < 32'h18);
    assign w_sel   = w_act & IBUS_REQ;
    assign w_idx   = w_off[4:2];
    assign w_acc   = w_sel & ~r_bsy;
    assign w_wr    = w_acc & IBUS_WE;
    assign w_start = w_wr & ((w_idx == 3'd1) | (w_idx == 3'd5));
    assign w_reset = RST | (CE_R & ~RES_N);
    assign w_wdw   = w_wdata[W-1:0];

    // Register read multiplexer
    always_comb begin
        w_rdata = 32'd0;
        case (w_idx)
            3'd0:    w_rdata = f_ext(r_dvsr, r_uns);
            3'd1:    w_rdata = f_ext(r_dvdntl, r_uns);
            3'd2:    w_rdata = {26'd0, r_bsy, r_doneie, r_done, r_uns, r_ovfie, r_ovf};
            3'd3:    w_rdata = {16'd0, r_vcrdiv};
            3'd4:    w_rdata = f_ext(r_dvdnth, r_uns);
            3'd5:    w_rdata = f_ext(r_dvdntl, r_uns);
            default: w_rdata = 32'd0;
        endcase
    end

    // Byte-enable merge: disabled lanes keep the register's current contents
    always_comb begin
        w_wdata = w_rdata;
        for (int i = 0; i < 4; i++) begin
            if (IBUS_BA[i]) w_wdata[8*i +: 8] = IBUS_DI[8*i +: 8];
        end
    end

    // LOAD-stage magnitudes, signs and overflow precheck
    logic [2*W-1:0] w_dvd, w_dmag;
    logic [W-1:0]   w_vmag;
    logic           w_dneg, w_vneg, w_pre;

    assign w_dvd  = {r_dvdnth, r_dvdntl};
    assign w_dneg = ~r_uns & r_dvdnth[W-1];
    assign w_vneg = ~r_uns & r_dvsr[W-1];
    assign w_dmag = w_dneg ? -w_dvd : w_dvd;
    assign w_vmag = w_vneg ? -r_dvsr : r_dvsr;
    assign w_pre  = (r_dvsr == '0) | (w_dmag[2*W-1:W] >= w_vmag);

    // ITER: shift in next dividend bit, then subtract or add per remainder sign
    logic [W+1:0] w_shift, w_dext, w_next;
    assign w_dext  = {2'b00, r_dsr};
    assign w_shift = {r_rem[W:0], r_quo[W-1]};
    assign w_next  = r_rem[W+1] ? (w_shift + w_dext) : (w_shift - w_dext);

    // FIX: restore a negative final remainder, apply signs, check signed range
    logic [W+1:0] w_rfix;
    logic [W-1:0] w_rmag, w_rsgn, w_qsgn;
    logic         w_rovf;
    assign w_rfix = r_rem[W+1] ? (r_rem + w_dext) : r_rem;
    assign w_rmag = w_rfix[W-1:0];
    assign w_rsgn = r_rneg ? -w_rmag : w_rmag;
    assign w_qsgn = r_qneg ? -r_quo : r_quo;
    assign w_rovf = ~r_uns & ((~r_qneg & r_quo[W-1]) | (r_qneg & (r_quo > c_smin)));

    // Register file, bus writes and divider sequencing; write-back overrides bus
    always_ff @(posedge CLK) begin
        if (w_reset) begin
            r_dvsr   <= '0;
            r_dvdnth <= '0;
            r_dvdntl <= '0;
            r_vcrdiv <= '0;
            r_ovf    <= 1'b0;
            r_ovfie  <= 1'b0;
            r_uns    <= 1'b0;
            r_done   <= 1'b0;
            r_doneie <= 1'b0;
            r_bsy    <= 1'b0;
            r_state  <= c_st_idle;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_dsr    <= '0;
            r_qneg   <= 1'b0;
            r_rneg   <= 1'b0;
            r_xovf   <= 1'b0;
        end else if (CE_R) begin
            if (w_wr) begin
                case (w_idx)
                    3'd0: r_dvsr <= w_wdw;
                    3'd1: begin
                        r_dvdntl <= w_wdw;
                        r_dvdnth <= {W{~r_uns & w_wdw[W-1]}};
                    end
                    3'd2: begin
                        r_ovf    <= r_ovf & w_wdata[0];
                        r_ovfie  <= w_wdata[1];
                        r_uns    <= w_wdata[2];
                        r_done   <= r_done & w_wdata[3];
                        r_doneie <= w_wdata[4];
                    end
                    3'd3: r_vcrdiv <= w_wdata[15:0];
                    3'd4: r_dvdnth <= w_wdw;
                    3'd5: r_dvdntl <= w_wdw;
                    default: ;
                endcase
            end

            case (r_state)
                c_st_idle: begin
                    if (w_start) begin
                        r_state <= c_st_load;
                        r_bsy   <= 1'b1;
                    end
                end
                c_st_load: begin
                    r_rem  <= {2'b00, w_dmag[2*W-1:W]};
                    r_quo  <= w_dmag[W-1:0];
                    r_dsr  <= w_vmag;
                    r_qneg <= w_dneg ^ w_vneg;
                    r_rneg <= w_dneg;
                    r_xovf <= w_pre;
                    r_cnt  <= '0;
                    r_state <= w_pre ? c_st_wb : c_st_iter;
                end
                c_st_iter: begin
                    r_rem <= w_next;
                    r_quo <= {r_quo[W-2:0], ~w_next[W+1]};
                    r_cnt <= r_cnt + c_cw'(1);
                    if (r_cnt == c_last) r_state <= c_st_fix;
                end
                c_st_fix: begin
                    r_rem   <= {2'b00, w_rsgn};
                    r_quo   <= w_qsgn;
                    r_xovf  <= w_rovf;
                    r_state <= c_st_wb;
                end
                c_st_wb: begin
                    if (r_xovf) begin
                        r_ovf    <= 1'b1;
                        r_dvdnth <= '0;
                        r_dvdntl <= r_uns ? {W{1'b1}} : (r_qneg ? c_smin : c_smax);
                    end else begin
                        r_dvdntl <= r_quo;
                        r_dvdnth <= r_rem[W-1:0];
                    end
                    r_done  <= 1'b1;
                    r_bsy   <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Read data captured on the falling-phase enable
    always_ff @(posedge CLK) begin
        if (w_reset)   r_do <= 32'd0;
        else if (CE_F) r_do <= w_sel ? w_rdata : 32'd0;
    end

    assign IBUS_DO   = w_sel ? r_do : 32'd0;
    assign IBUS_BUSY = w_sel & r_bsy;
    assign IBUS_ACT  = w_act;
    assign IRQ       = (r_ovf & r_ovfie) | (r_done & r_doneie);
    assign VEC       = r_vcrdiv[7:0];

endmodule
`default_nettype wire

// File: tb/tb_divu_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_divu_param
// Description : Directed self-checking bench for divu_param (W=32 and W=16).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_divu_param;

    localparam logic [31:0] c_base = 32'hFFFFFF00;

    logic        CLK = 1'b0;
    logic        RST, CE_R, CE_F, RES_N;
    logic [31:0] A, DI;
    logic [3:0]  BA;
    logic        WE, req32, req16;
    logic [31:0] do32, do16;
    logic        busy32, busy16, act32, act16, irq32, irq16;
    logic [7:0]  vec32, vec16;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    divu_param #(.W(32), .BASE(c_base)) dut (
        .CLK(CLK), .RST(RST), .CE_R(CE_R), .CE_F(CE_F), .RES_N(RES_N),
        .IBUS_A(A), .IBUS_DI(DI), .IBUS_BA(BA), .IBUS_WE(WE), .IBUS_REQ(req32),
        .IBUS_DO(do32), .IBUS_BUSY(busy32), .IBUS_ACT(act32), .IRQ(irq32), .VEC(vec32)
    );

    divu_param #(.W(16), .BASE(c_base)) dut16 (
        .CLK(CLK), .RST(RST), .CE_R(CE_R), .CE_F(CE_F), .RES_N(RES_N),
        .IBUS_A(A), .IBUS_DI(DI), .IBUS_BA(BA), .IBUS_WE(WE), .IBUS_REQ(req16),
        .IBUS_DO(do16), .IBUS_BUSY(busy16), .IBUS_ACT(act16), .IRQ(irq16), .VEC(vec16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus access; waits out stalls and reports how many cycles it stalled
    task automatic bus_acc(input bit which, input bit we, input logic [31:0] off,
                           input logic [31:0] data, input logic [3:0] ba,
                           output logic [31:0] rd, output int stalls);
        bit fin;
        fin = 1'b0; stalls = 0; rd = 32'd0;
        @(negedge CLK);
        A = c_base + off; DI = data; BA = ba; WE = we;
        req32 = ~which; req16 = which;
        for (int i = 0; i < 300 && !fin; i++) begin
            #1;
            if ((which ? busy16 : busy32) == 1'b0) begin
                @(posedge CLK); #1;
                rd  = which ? do16 : do32;
                fin = 1'b1;
            end else begin
                stalls++;
                @(negedge CLK);
            end
        end
        req32 = 1'b0; req16 = 1'b0; WE = 1'b0;
        chk("access_timeout", {31'd0, fin}, 32'd1);
    endtask

    task automatic wr(input bit which, input logic [31:0] off, input logic [31:0] data);
        logic [31:0] d; int s;
        bus_acc(which, 1'b1, off, data, 4'hF, d, s);
    endtask

    task automatic rdchk(input bit which, input logic [31:0] off, input string tag,
                         input logic [31:0] exp);
        logic [31:0] d; int s;
        bus_acc(which, 1'b0, off, 32'd0, 4'hF, d, s);
        chk(tag, d, exp);
    endtask

    task automatic rdstall(input bit which, input logic [31:0] off, input string tag,
                           input logic [31:0] exp, input int exp_st);
        logic [31:0] d; int s;
        bus_acc(which, 1'b0, off, 32'd0, 4'hF, d, s);
        chk(tag, d, exp);
        chk({tag, "_stalls"}, 32'(s), 32'(exp_st));
    endtask

    initial begin
        logic [31:0] d;
        int          s;
        RST = 1'b1; RES_N = 1'b1; CE_R = 1'b1; CE_F = 1'b1;
        A = 32'd0; DI = 32'd0; BA = 4'hF; WE = 1'b0; req32 = 1'b0; req16 = 1'b0;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;

        // Reset state
        #1;
        chk("rst_do", do32, 32'd0);
        chk("rst_busy", {31'd0, busy32}, 32'd0);
        chk("rst_irq", {31'd0, irq32}, 32'd0);
        chk("rst_vec", {24'd0, vec32}, 32'd0);
        rdchk(0, 32'h00, "rst_dvsr", 32'd0);
        rdchk(0, 32'h08, "rst_dvcr", 32'd0);
        rdchk(0, 32'h0C, "rst_vcrdiv", 32'd0);
        rdchk(0, 32'h10, "rst_dvdnth", 32'd0);
        rdchk(0, 32'h14, "rst_dvdntl", 32'd0);

        // Address decode window
        @(negedge CLK);
        A = c_base + 32'h14; #1;
        chk("act_in", {30'd0, act16, act32}, 32'd3);
        A = c_base + 32'h18; #1;
        chk("act_out", {30'd0, act16, act32}, 32'd0);

        // Vector register and byte enables
        wr(0, 32'h0C, 32'h0000_1234);
        chk("vec_full", {24'd0, vec32}, 32'h34);
        bus_acc(0, 1'b1, 32'h0C, 32'h0000_FFFF, 4'b0001, d, s);
        rdchk(0, 32'h0C, "vcrdiv_byte", 32'h0000_12FF);
        chk("vec_byte", {24'd0, vec32}, 32'hFF);

        // Signed W/W: 100 / -7 = -14 r 2
        wr(0, 32'h00, 32'hFFFF_FFF9);
        wr(0, 32'h04, 32'd100);
        repeat (35) @(posedge CLK);
        #1;
        rdstall(0, 32'h14, "s_q", 32'hFFFF_FFF2, 0);
        rdchk(0, 32'h10, "s_r", 32'h0000_0002);
        rdchk(0, 32'h08, "s_dvcr", 32'h0000_0008);
        chk("s_irq", {31'd0, irq32}, 32'd0);

        // Unsigned W/W: 0xFFFFFFFF / 2
        wr(0, 32'h08, 32'h0000_0004);
        wr(0, 32'h00, 32'd2);
        wr(0, 32'h04, 32'hFFFF_FFFF);
        rdchk(0, 32'h14, "u_q", 32'h7FFF_FFFF);
        rdchk(0, 32'h10, "u_r", 32'h0000_0001);
        rdchk(0, 32'h08, "u_dvcr", 32'h0000_000C);

        // Divide by zero: precheck overflow, write-back two cycles after start
        wr(0, 32'h08, 32'h0000_0002);
        wr(0, 32'h00, 32'd0);
        wr(0, 32'h04, 32'd5);
        rdstall(0, 32'h14, "z_q", 32'h7FFF_FFFF, 2);
        rdchk(0, 32'h10, "z_r", 32'd0);
        rdchk(0, 32'h08, "z_dvcr", 32'h0000_000B);
        chk("z_irq", {31'd0, irq32}, 32'd1);
        wr(0, 32'h08, 32'h0000_0002);
        chk("z_irq_clr", {31'd0, irq32}, 32'd0);
        wr(0, 32'h08, 32'h0000_000B);
        rdchk(0, 32'h08, "flag_w1_noeffect", 32'h0000_0002);

        // 2W/W signed: -2^31 / 1 fits, -2^31 / -1 overflows
        wr(0, 32'h08, 32'd0);
        wr(0, 32'h00, 32'd1);
        wr(0, 32'h10, 32'hFFFF_FFFF);
        wr(0, 32'h14, 32'h8000_0000);
        rdchk(0, 32'h14, "l_q_div1", 32'h8000_0000);
        rdchk(0, 32'h10, "l_r_div1", 32'd0);
        rdchk(0, 32'h08, "l_dvcr_div1", 32'h0000_0008);
        wr(0, 32'h00, 32'hFFFF_FFFF);
        wr(0, 32'h10, 32'hFFFF_FFFF);
        wr(0, 32'h14, 32'h8000_0000);
        rdchk(0, 32'h14, "l_q_divm1", 32'h7FFF_FFFF);
        rdchk(0, 32'h10, "l_r_divm1", 32'd0);
        rdchk(0, 32'h08, "l_dvcr_divm1", 32'h0000_0009);

        // Read stalled from LOAD+5 until write-back
        wr(0, 32'h08, 32'd0);
        wr(0, 32'h00, 32'd7);
        wr(0, 32'h04, 32'd100);
        repeat (5) @(posedge CLK);
        rdstall(0, 32'h14, "st_q", 32'd14, 30);

        // Second start while busy is deferred and then executes
        wr(0, 32'h04, 32'd100);
        bus_acc(0, 1'b1, 32'h04, 32'hFFFF_FF9C, 4'hF, d, s);
        chk("defer_stalls", 32'(s), 32'd35);
        rdstall(0, 32'h14, "defer_q", 32'hFFFF_FFF2, 35);
        rdchk(0, 32'h10, "defer_r", 32'hFFFF_FFFE);

        // RST during ITER 10 aborts and clears everything
        wr(0, 32'h08, 32'h0000_0012);
        wr(0, 32'h04, 32'd100);
        repeat (10) @(posedge CLK);
        @(negedge CLK); RST = 1'b1;
        @(posedge CLK); #1 RST = 1'b0;
        chk("ar_irq", {31'd0, irq32}, 32'd0);
        chk("ar_vec", {24'd0, vec32}, 32'd0);
        rdstall(0, 32'h14, "ar_dvdntl", 32'd0, 0);
        rdchk(0, 32'h10, "ar_dvdnth", 32'd0);
        rdchk(0, 32'h00, "ar_dvsr", 32'd0);
        rdchk(0, 32'h08, "ar_dvcr", 32'd0);
        rdchk(0, 32'h0C, "ar_vcrdiv", 32'd0);

        // Fresh run after reset
        wr(0, 32'h00, 32'd7);
        wr(0, 32'h04, 32'd100);
        rdchk(0, 32'h14, "post_q", 32'd14);
        rdchk(0, 32'h10, "post_r", 32'd2);

        // Soft reset through RES_N
        @(negedge CLK); RES_N = 1'b0;
        @(posedge CLK); #1 RES_N = 1'b1;
        rdchk(0, 32'h14, "resn_dvdntl", 32'd0);

        // W=16 instance: identical results, narrow registers read back extended
        wr(1, 32'h00, 32'd7);
        wr(1, 32'h04, 32'd100);
        rdstall(1, 32'h14, "w16_q", 32'd14, 19);
        rdchk(1, 32'h10, "w16_r", 32'd2);
        wr(1, 32'h00, 32'hFFFF_FFF9);
        wr(1, 32'h04, 32'd100);
        rdchk(1, 32'h14, "w16_sq", 32'hFFFF_FFF2);
        rdchk(1, 32'h10, "w16_sr", 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/divu_param.md
# divu_param

Parametrised divide unit for the SH on-chip peripheral bus: 2W/W and W/W division, signed or unsigned, one quotient bit per CE_R step. It also provides quotient-range overflow detection with saturation, an overflow interrupt and a completion interrupt, and bus stall while busy. It sits on the internal bus at BASE with the same register layout as the existing divider, extended by mode and status bits in DVCR.

## Interface
- W, 32: operand width, 8..32; registers narrower than 32 bits read back sign-extended (signed mode) or zero-extended (unsigned mode).
- BASE, 32'hFFFFFF00: register block base; block decodes BASE..BASE+0x17.
- CLK  in  1  clock, single domain, all state updates gated by CE_R (registers/divider) or CE_F (read data).
- RST  in  1  reset, synchronous, active-high; sampled on CLK edge regardless of CE.
- CE_R, CE_F  in  1  rising/falling-phase clock enables.
- RES_N  in  1  module soft reset, active-low, sampled on CE_R; same effect as RST.
- IBUS_A  in  32  address. IBUS_DI in 32 write data. IBUS_BA in 4 byte enables. IBUS_WE in 1 write. IBUS_REQ in 1 request.
- IBUS_DO  out  32  read data, 0 when not selected.
- IBUS_BUSY  out  1  stall; high while a selected access waits for the divider.
- IBUS_ACT  out  1  address in block range.
- IRQ  out  1  (DVCR.OVF & OVFIE) | (DVCR.DONE & DONEIE).
- VEC  out  8  VCRDIV[7:0].

## Operation
- Registers (offset): 00 DVSR; 04 DVDNT (write = W/W start, sign/zero-extend into DVDNTH:DVDNTL); 08 DVCR; 0C VCRDIV[15:0]; 10 DVDNTH; 14 DVDNTL (write = 2W/W start).
- DVCR: bit0 OVF, bit1 OVFIE, bit2 UNS (1 = unsigned), bit3 DONE, bit4 DONEIE, bit5 BSY (read-only). OVF/DONE set by hardware, cleared by writing 0; writing 1 has no effect.
- Start only when idle; a start write (or any selected access) while BSY is stalled via IBUS_BUSY until idle, then executes.
- STEP states: IDLE -> LOAD -> ITER(1..W) -> FIX -> WB -> IDLE.
- LOAD: capture magnitudes |DVDNTH:DVDNTL| (2W bits) and |DVSR| (UNS: raw), record result signs. Precheck overflow if DVSR==0 or magnitude-high >= |DVSR|; precheck overflow jumps directly to WB.
- ITER: non-restoring, one quotient bit per step, W-bit partial remainder plus carry.
- FIX: remainder correction, then apply signs. Quotient sign = dividend sign XOR divisor sign; remainder sign = dividend sign. Range overflow (signed only): positive quotient magnitude > 2^(W-1)-1, or negative quotient magnitude > 2^(W-1).
- WB (overflow): OVF<=1, DVDNTH<=0. DVDNTL<=all-ones if UNS; otherwise 2^(W-1)-1 if true quotient positive, -2^(W-1) if negative.
- WB (no overflow): DVDNTL<=quotient, DVDNTH<=remainder.
- WB always sets DONE<=1 and BSY<=0.
- Bus writes and WB in the same CE_R cycle: WB wins for DVDNTH/DVDNTL/OVF/DONE. Other DVCR bits take the bus write.

## Timing
- Start write on CE_R cycle n: LOAD at n+1, ITER n+2..n+W+1, FIX n+W+2, WB n+W+3. Results are readable from cycle n+W+4.
- Precheck overflow: WB at n+2.
- BSY/IBUS_BUSY assert from the cycle after the start write until the WB cycle inclusive. The stalled access completes on the first idle CE_R; read data is valid on the following CE_F.
- Read data registered on CE_F; IBUS_DO = REG_DO when selected.
- Reset (RST or !RES_N), including mid-operation: abort to IDLE. All registers go to 0 (UNS=0). IBUS_DO=0, IBUS_BUSY=0, IRQ=0, VEC=0.

## Test plan
- W=32, signed: DVSR=-7, write DVDNT=100 -> after 35 CE_R, DVDNTL=0xFFFFFFF2 (-14), DVDNTH=2, OVF=0, DONE=1.
- UNS=1: DVSR=2, DVDNT=0xFFFFFFFF -> DVDNTL=0x7FFFFFFF, DVDNTH=1.
- DVSR=0, DVDNT=5, OVFIE=1 -> WB 2 cycles after start; OVF=1, IRQ=1, DVDNTL=0x7FFFFFFF, DVDNTH=0.
- 2W/W signed, DVDNTH=0xFFFFFFFF, DVDNTL=0x80000000:
  - DVSR=1 -> q=0x80000000, no overflow.
  - DVSR=-1 -> range overflow, DVDNTL=0x7FFFFFFF.
- Read DVDNTL at LOAD+5 -> IBUS_BUSY high until WB, then returns the quotient. A second start during BSY is deferred and runs after WB.
- RST asserted at ITER 10 -> next edge IDLE, all registers 0. A new 100/7 run gives q=14, r=2. Repeat with W=16 parameterisation for identical results.
